cla_16bit: RTL and testbench
============================

Name: cla_16bit

Overview:
- 16-bit carry-lookahead adder computing A + B + C_In, producing a 16-bit Sum and a carry-out.
- Two-level lookahead: four 4-bit CLA groups whose group generate/propagate signals feed a second-level carry unit.
- Result is registered on the clock, so the block drops into a pipelined datapath as a one-cycle arithmetic stage.

Parameters:
- None. The width is fixed at 16 bits, organised as 4 groups of 4 bits.

Ports:
clk    input   1   system clock, rising-edge active
rst    input   1   asynchronous, active-high reset
A      input   16  addend A, unsigned
B      input   16  addend B, unsigned
C_In   input   1   carry-in into bit 0
Sum    output  16  registered (A + B + C_In) mod 2^16
c_out  output  1   registered carry-out of bit 15

Behaviour:
- Bit level:
  - p[i] = A[i] ^ B[i]
  - g[i] = A[i] & B[i]
  - sum bit i = p[i] ^ c[i], with c[0] = C_In
- Group level (k = 0..3, bits 4k..4k+3):
  - In-group carries come from lookahead equations, not ripple.
  - Group propagate PG[k] = AND of its four p bits.
  - Group generate GG[k] = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
- Second level:
  - C4, C8, C12 and C16 are computed in two-level sum-of-products form from GG, PG and C_In.
  - C16 is the carry-out.
- Arithmetic: the 17-bit result {c_out, Sum} equals A + B + C_In exactly. There is no signed or overflow flag.
- Registering:
  - On each rising clk edge with rst low, Sum and c_out capture the combinational result of the current A, B and C_In.
  - Latency is 1 cycle; throughput is 1 addition per cycle. There is no handshake and no enable.
- Reset:
  - While rst is high, Sum = 16'h0000 and c_out = 0, asynchronously and independent of clk.
  - On deassertion, the first rising edge captures a valid result.
  - Reset asserted mid-stream discards the in-flight result.
- Boundaries:
  - 16'hFFFF + 16'h0000 + 1 gives Sum = 0, c_out = 1.
  - 16'hFFFF + 16'hFFFF + 1 gives Sum = 16'hFFFF, c_out = 1.
  - 0 + 0 + 0 gives Sum = 0, c_out = 0.
- Inputs that change between edges only affect the next capture. There are no state machines.

Decomposition:
- Shared package holds CLA_WIDTH = 16, CLA_GROUP = 4 and CLA_NGROUPS = 4.
- Sub-module cla_4bit: inputs a[3:0], b[3:0], cin. Outputs s[3:0], group propagate pg and group generate gg.
- cla_16bit instantiates four cla_4bit, contains the second-level lookahead logic, and holds the output register.

Test Plan:
- Reset check: assert rst with arbitrary inputs -> Sum = 0, c_out = 0 immediately and with no clk edge required. Release rst -> valid result appears one edge later.
- Basic adds, one cycle after apply:
  - A=16, B=128, C_In=1 -> Sum=145, c_out=0
  - A=512, B=1073, C_In=1 -> Sum=1586
  - A=100, B=8, C_In=0 -> Sum=108
- Group-crossing carries:
  - A=1216, B=225, C_In=1 -> Sum=1442
  - A=11264, B=8340, C_In=1 -> Sum=19605
  - A=33792, B=6144, C_In=0 -> Sum=39936, c_out=0
- Carry-out:
  - A=32774, B=50209, C_In=0 -> Sum=17447, c_out=1
  - A=65535, B=0, C_In=1 -> Sum=0, c_out=1 (full propagate chain)
- Pipeline: apply the sequence above back to back, one per cycle -> each result appears exactly one cycle after its operands, with no bubbles.
- Random: 10k random A, B, C_In compared against a 17-bit reference sum. Assert rst mid-run -> outputs clear at once and resume correctly after release.

Source files
------------

// File: rtl/cla_16bit_pkg.sv
// Shared sizing for the 16-bit two-level carry-lookahead adder.
// The datapath is split into CLA_NGROUPS groups of CLA_GROUP bits each.
package cla_16bit_pkg;
  localparam int CLA_WIDTH   = 16;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;
endpackage

// File: rtl/cla_16bit_cla4.sv
// 4-bit carry-lookahead group: local sums plus group propagate/generate
// for the second-level carry unit.
module cla_4bit
  import cla_16bit_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 pg,
  output logic                 gg
);

  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] c;

  always_comb begin
    p = a ^ b;
    g = a & b;

    // In-group carries are flat sum-of-products, never rippled.
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);

    s  = p ^ c;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder with a registered result,
// usable as a single-cycle arithmetic stage in a pipelined datapath.
module cla_16bit
  import cla_16bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] A,
  input  logic [CLA_WIDTH-1:0] B,
  input  logic                 C_In,
  output logic [CLA_WIDTH-1:0] Sum,
  output logic                 c_out
);

  logic [CLA_NGROUPS-1:0] pg;
  logic [CLA_NGROUPS-1:0] gg;
  logic [CLA_NGROUPS:0]   gc;
  logic [CLA_WIDTH-1:0]   sum_d;
  logic [CLA_WIDTH-1:0]   sum_q;
  logic                   cout_d;
  logic                   cout_q;

  for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_grp
    cla_4bit u_grp (
      .a   (A[k*CLA_GROUP +: CLA_GROUP]),
      .b   (B[k*CLA_GROUP +: CLA_GROUP]),
      .cin (gc[k]),
      .s   (sum_d[k*CLA_GROUP +: CLA_GROUP]),
      .pg  (pg[k]),
      .gg  (gg[k])
    );
  end

  // Second-level group carries, each a two-level SOP of GG/PG and C_In.
  always_comb begin
    gc[0] = C_In;
    gc[1] = gg[0] | (pg[0] & C_In);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & C_In);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & C_In);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & C_In);
    cout_d = gc[4];
  end

  // Output stage: asynchronous clear discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_cla_16bit.sv
// Directed and random checks of cla_16bit through an expected-result queue.
module tb_cla_16bit;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [15:0] A    = '0;
  logic [15:0] B    = '0;
  logic        C_In = 1'b0;
  logic [15:0] Sum;
  logic        c_out;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  cla_16bit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C_In  (C_In),
    .Sum   (Sum),
    .c_out (c_out)
  );

  task automatic chk(input string tag, input logic [16:0] exp);
    total++;
    assert ({c_out, Sum} === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, {c_out, Sum}, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [16:0] exp);
    A = a; B = b; C_In = c;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // One cycle: check whatever the last edge produced, then apply new operands.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [16:0] exp);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) chk(tag_q.pop_front(), exp_q.pop_front());
    drive(tag, a, b, c, exp);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) chk(tag_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;

    // Reset with arbitrary operands: clear must appear before any clock edge.
    A = 16'hBEEF; B = 16'h1234; C_In = 1'b1;
    rst = 1'b1;
    #2;
    chk("rst_async", 17'h0);
    @(posedge clk);
    #1;
    chk("rst_hold", 17'h0);

    // Release: the very next edge must capture a valid result.
    rst = 1'b0;
    drive("basic1", 16'd16, 16'd128, 1'b1, 17'd145);
    step("basic2", 16'd512,   16'd1073,  1'b1, 17'd1586);
    step("basic3", 16'd100,   16'd8,     1'b0, 17'd108);
    step("xgrp1",  16'd1216,  16'd225,   1'b1, 17'd1442);
    step("xgrp2",  16'd11264, 16'd8340,  1'b1, 17'd19605);
    step("xgrp3",  16'd33792, 16'd6144,  1'b0, 17'd39936);
    step("cout1",  16'd32774, 16'd50209, 1'b0, {1'b1, 16'd17447});
    step("cout2",  16'hFFFF,  16'h0000,  1'b1, {1'b1, 16'h0000});
    step("allone", 16'hFFFF,  16'hFFFF,  1'b1, {1'b1, 16'hFFFF});
    step("zero",   16'h0000,  16'h0000,  1'b0, 17'h0);
    step("p_only", 16'hAAAA,  16'h5555,  1'b0, 17'h0FFFF);
    step("p_cin",  16'hAAAA,  16'h5555,  1'b1, 17'h10000);
    drain();

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      rc = 1'($urandom_range(0, 1));
      step("rand", ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'h0, rc});
      if (i == 5000) begin
        // Mid-stream reset: in-flight result is dropped, output clears at once.
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_async", 17'h0);
        exp_q.delete();
        tag_q.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_hold", 17'h0);
        rst = 1'b0;
        drive("rst_mid_resume", 16'h8001, 16'h7FFF, 1'b1, 17'h10001);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
